// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: register indices, CTRL/STATUS bit positions, FSM states.
package uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_BAUD   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;

  localparam int CTRL_RX_EN    = 0;
  localparam int CTRL_TWO_STOP = 1;
  localparam int CTRL_ODD_PAR  = 2;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_PERR     = 2;
  localparam int STAT_FERR     = 3;
  localparam int STAT_OVR      = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_PUSH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO, registered write, head visible combinationally; a push while full is ignored
// unless a pop happens in the same cycle, in which case both take effect.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver (start, 8 data LSB first, parity, 1/2 stop) feeding a byte FIFO.
// Byte readable one clk after the PUSH decision; a full FIFO drops the byte and raises overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  input  logic        Rx_in,
  output logic        rx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [13:0] baud_q, baud_d;
  logic        perr_st_q, perr_st_d;
  logic        ferr_st_q, ferr_st_d;
  logic        ovr_st_q, ovr_st_d;

  rx_state_e   state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        perr_q, perr_d;

  logic          tick, half_tick;
  logic          rx_en, two_stop, odd_par;
  logic          push, set_ferr;
  logic          wr_ctrl, wr_status, wr_baud, rd_data;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [4:0]    status;
  logic          unused_bits;

  assign sync_d    = SYNC_STAGES'({sync_q, Rx_in});
  assign rx_s      = sync_q[SYNC_STAGES-1];

  assign rx_en     = ctrl_q[CTRL_RX_EN];
  assign two_stop  = ctrl_q[CTRL_TWO_STOP];
  assign odd_par   = ctrl_q[CTRL_ODD_PAR];

  assign tick      = (cnt_q == baud_q);
  assign half_tick = (cnt_q == (baud_q >> 1));

  assign wr_ctrl   = wr_en && (addr[2:0] == REG_CTRL);
  assign wr_status = wr_en && (addr[2:0] == REG_STATUS);
  assign wr_baud   = wr_en && (addr[2:0] == REG_BAUD);
  assign rd_data   = rd_en && (addr[2:0] == REG_DATA);
  assign fifo_pop  = rd_data && !fifo_empty;

  assign unused_bits = ^{addr[31:3], wdata[31:14]};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    perr_d   = perr_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    case (state_q)
      RX_IDLE: begin
        perr_d   = 1'b0;
        bitcnt_d = '0;
        if (!rx_s && rx_en && (baud_q != '0)) state_d = RX_START;
      end
      RX_START: begin
        // Restarting the count here puts every later tick in the middle of its bit.
        if (half_tick) state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (tick) begin
          shreg_d  = {rx_s, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (tick) begin
          perr_d  = rx_s != (odd_par ? ~^shreg_q : ^shreg_q);
          state_d = RX_STOP1;
        end
      end
      RX_STOP1: begin
        if (tick) begin
          if (!rx_s) begin
            set_ferr = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            state_d  = two_stop ? RX_STOP2 : RX_PUSH;
          end
        end
      end
      RX_STOP2: begin
        if (tick) begin
          if (!rx_s) begin
            set_ferr = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            state_d  = RX_PUSH;
          end
        end
      end
      RX_PUSH: begin
        push    = 1'b1;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    // Disabling the receiver abandons whatever frame is in flight.
    if ((state_q != RX_IDLE) && !rx_en) begin
      state_d  = RX_IDLE;
      push     = 1'b0;
      set_ferr = 1'b0;
    end
  end

  always_comb begin
    if ((state_q == RX_IDLE) || (state_d != state_q) || tick) cnt_d = '0;
    else                                                      cnt_d = cnt_q + 14'd1;
  end

  always_comb begin
    ctrl_d    = wr_ctrl ? wdata[2:0]  : ctrl_q;
    baud_d    = wr_baud ? wdata[13:0] : baud_q;
    // Clear first, then set, so an error landing on a W1C cycle survives.
    perr_st_d = (perr_st_q & ~(wr_status & wdata[STAT_PERR])) | (push & perr_q);
    ferr_st_d = (ferr_st_q & ~(wr_status & wdata[STAT_FERR])) | set_ferr;
    ovr_st_d  = (ovr_st_q  & ~(wr_status & wdata[STAT_OVR]))  | (push & fifo_full & !fifo_pop);

    status                = '0;
    status[STAT_NONEMPTY] = !fifo_empty;
    status[STAT_FULL]     = fifo_full;
    status[STAT_PERR]     = perr_st_q;
    status[STAT_FERR]     = ferr_st_q;
    status[STAT_OVR]      = ovr_st_q;

    rdata = '0;
    if (rd_en) begin
      case (addr[2:0])
        REG_DATA:   rdata = fifo_empty ? 32'd0 : {24'd0, fifo_rdata};
        REG_CTRL:   rdata = {29'd0, ctrl_q};
        REG_STATUS: rdata = {27'd0, status};
        REG_BAUD:   rdata = {18'd0, baud_q};
        REG_COUNT:  rdata = 32'(fifo_count);
        default:    rdata = '0;
      endcase
    end
  end

  assign rx_irq = !fifo_empty || perr_st_q || ferr_st_q || ovr_st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      ctrl_q    <= '0;
      baud_q    <= '0;
      perr_st_q <= 1'b0;
      ferr_st_q <= 1'b0;
      ovr_st_q  <= 1'b0;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      perr_st_q <= perr_st_d;
      ferr_st_q <= ferr_st_d;
      ovr_st_q  <= ovr_st_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shreg_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx against a queue-based model of the receive path.
module tb_uart_rx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        wr_en, rd_en, Rx_in, rx_irq;

  uart_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .rdata  (rdata),
    .Rx_in  (Rx_in),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          miscmp  = 0;
  logic [7:0]  mq[$];
  logic        st_perr, st_ferr, st_ovr;
  logic [2:0]  ctrl_m;
  logic [13:0] baud_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    v = rdata;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] c, input logic [13:0] b);
    reg_write(32'd1, {29'd0, c});
    reg_write(32'd3, {18'd0, b});
    ctrl_m = c;
    baud_m = b;
  endtask

  task automatic w1c(input logic [31:0] m);
    reg_write(32'd2, m);
    if (m[2]) st_perr = 1'b0;
    if (m[3]) st_ferr = 1'b0;
    if (m[4]) st_ovr  = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    st_perr = 1'b0; st_ferr = 1'b0; st_ovr = 1'b0;
    ctrl_m = '0; baud_m = '0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v, e;
    reg_read(32'd4, v);
    check_eq({tag, "_count"}, v, 32'(mq.size()));
    e = '0;
    e[0] = (mq.size() != 0);
    e[1] = (mq.size() == DEPTH);
    e[2] = st_perr;
    e[3] = st_ferr;
    e[4] = st_ovr;
    reg_read(32'd2, v);
    check_eq({tag, "_status"}, v, e);
    check_eq({tag, "_irq"}, {31'd0, rx_irq}, {31'd0, (mq.size() != 0) | st_perr | st_ferr | st_ovr});
  endtask

  task automatic read_data(input string tag);
    logic [31:0] v, e;
    reg_read(32'd0, v);
    e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
    check_eq(tag, v, e);
  endtask

  // Drives one frame at (baud+1) clocks per bit; optional DATA pop or reset at a given cycle.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_s1,
                            input bit bad_s2, input int pop_at, input int rst_at);
    logic bits[12];
    logic [31:0] e;
    int bp, nb;
    bit ferr, perr;
    bp = int'(baud_m) + 1;
    nb = ctrl_m[1] ? 12 : 11;
    perr = bad_par;
    ferr = bad_s1 || (ctrl_m[1] && bad_s2);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9]  = (ctrl_m[2] ? ~^d : ^d) ^ bad_par;
    bits[10] = ~bad_s1;
    bits[11] = ~bad_s2;
    for (int i = 0; i < nb * bp; i++) begin
      Rx_in = bits[i / bp];
      if (i == pop_at) begin addr = 32'd0; rd_en = 1'b1; end
      if (i == rst_at) reset = 1'b1;
      @(negedge clk);
      if (i == pop_at) begin
        e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
        check_eq("pop_on_push", rdata, e);
      end
      cyc();
      rd_en = 1'b0;
      reset = 1'b0;
    end
    Rx_in = 1'b1;
    if (rst_at >= 0) begin
      model_reset();
    end else if (ferr) begin
      st_ferr = 1'b1;
    end else begin
      if (perr) st_perr = 1'b1;
      if (mq.size() == DEPTH) st_ovr = 1'b1;
      else mq.push_back(d);
    end
    repeat (2 * bp + 4) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int pp;
    reset = 1'b1; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0; Rx_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    reg_read(32'd1, v); check_eq("rst_ctrl", v, 32'd0);
    reg_read(32'd3, v); check_eq("rst_baud", v, 32'd0);
    check_state("rst");

    // Basic even-parity byte
    cfg(3'd1, 14'd9);
    reg_read(32'd1, v); check_eq("ctrl_rb", v, 32'd1);
    reg_read(32'd3, v); check_eq("baud_rb", v, 32'd9);
    addr = 32'd3; rd_en = 1'b0;
    @(negedge clk); check_eq("rdata_idle", rdata, 32'd0);
    cyc();
    send_frame(8'hA5, 0, 0, 0, -1, -1);
    check_state("a5");
    read_data("a5_data");
    check_state("a5_drained");

    // Odd parity with wrong parity bit, then W1C
    cfg(3'd5, 14'd9);
    send_frame(8'h3C, 1, 0, 0, -1, -1);
    check_state("perr");
    read_data("perr_data");
    w1c(32'h4);
    check_state("perr_clr");

    // Framing error then a clean byte
    cfg(3'd1, 14'd9);
    send_frame(8'h55, 0, 1, 0, -1, -1);
    check_state("ferr");
    send_frame(8'h12, 0, 0, 0, -1, -1);
    read_data("after_ferr");
    w1c(32'h1C);
    check_state("ferr_clr");

    // Overrun, then the same with a pop on byte 9's PUSH cycle
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, -1, -1);
    check_state("ovr");
    for (int i = 0; i < 8; i++) read_data("ovr_data");
    w1c(32'h1C);
    check_state("ovr_clr");
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0, 0, -1, -1);
    pp = SYNC + 2 + (int'(baud_m) >> 1) + 10 * (int'(baud_m) + 1);
    send_frame(8'h09, 0, 0, 0, pp, -1);
    check_state("nopovr");
    for (int i = 0; i < 8; i++) read_data("nopovr_data");

    // Short low glitch
    Rx_in = 1'b0;
    repeat (3) cyc();
    Rx_in = 1'b1;
    repeat (30) cyc();
    check_state("glitch");

    // Two stop bits, bad second stop; then reset mid-frame
    cfg(3'd3, 14'd9);
    send_frame(8'hFF, 0, 0, 1, -1, -1);
    check_state("ferr2");
    send_frame(8'h77, 0, 0, 0, -1, 50);
    reg_read(32'd1, v); check_eq("rst2_ctrl", v, 32'd0);
    reg_read(32'd3, v); check_eq("rst2_baud", v, 32'd0);
    check_state("rst2");

    reg_read(32'd5, v); check_eq("addr5", v, 32'd0);
    reg_read(32'd7, v); check_eq("addr7", v, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] d;
      int r, k;
      if (n % 10 == 0) cfg({1'($urandom), 1'($urandom), 1'b1}, 14'($urandom_range(3, 14)));
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      send_frame(d, ($urandom_range(0, 5) == 0), (r == 0), (r == 1), -1, -1);
      check_state("rnd");
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) read_data("rnd_data");
      if ($urandom_range(0, 4) == 0) w1c($urandom & 32'h1C);
    end
    while (mq.size() != 0) read_data("final_data");
    check_state("final");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver. It is the downstream partner of the team's UART transmitter and consumes the same serial frame format.
- Frame: start bit (0), 8 data bits LSB first, one parity bit, then 1 or 2 stop bits (1).
- Oversamples the line with a per-bit baud counter, checks parity and framing, and buffers received bytes in an 8-entry FIFO that the core reads over the data bus.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, flip-flops in the Rx_in synchroniser.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- addr  in  32  register index; only bits [2:0] are decoded.
- wdata  in  32  write data.
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- rdata  out  32  read data, combinational.
- Rx_in  in  1  serial line, asynchronous, idles high.
- rx_irq  out  1  high when FIFO non-empty OR any sticky error bit is set.

Behaviour:
- Register map (word index):
  - 0 DATA (RO): FIFO head byte in [7:0]. A read with rd_en && addr==0 pops the FIFO. A read of an empty FIFO returns 0 and does not pop.
  - 1 CTRL (RW): [0] Rx_en, [1] Two_stop, [2] Odd_parity.
  - 2 STATUS: [0] fifo_nonempty, [1] fifo_full, [2] parity_err, [3] frame_err, [4] overrun. Bits [4:2] are sticky; writing 1 clears them (W1C), writing 0 has no effect.
  - 3 BAUD (RW): [13:0] divisor. Bit period is divisor+1 clocks.
  - 4 COUNT (RO): [4:0] FIFO occupancy.
  - Other addresses read 0.
- rdata = 0 when rd_en is low.
- Reset: all registers 0, FIFO empty, FSM in IDLE, rx_irq=0.
- Rx_in passes through SYNC_STAGES flops; rx_s is the synchronised value. All sampling uses rx_s.
- Baud counter: 14 bits. Cleared on every state entry. Counts up each clk while FSM is not IDLE. Tick when count == divisor, with the counter cleared on the same edge. Half-tick when count == divisor>>1.
- FSM states:
  - IDLE: waits for rx_s==0, Rx_en==1 and divisor!=0, then goes to START.
  - START: at half-tick, samples rx_s. If 0, go to DATA and clear the counter, so later samples land mid-bit. If 1, it was a glitch: go to IDLE with no flag set.
  - DATA: on each tick, shift rx_s into bit 7 of the shift register (LSB-first assembly). After the 8th tick go to PARITY.
  - PARITY: on tick, capture the parity bit. Expected value is ^data for even parity and ~^data when Odd_parity=1. A mismatch sets a local perr. Go to STOP1.
  - STOP1: on tick, if rx_s==0, set frame_err, discard the byte and go to IDLE. Otherwise go to STOP2 if Two_stop, else go to PUSH.
  - STOP2: same check as STOP1, then go to PUSH.
  - PUSH: lasts one cycle. Writes the byte to the FIFO and ORs perr into parity_err. Then goes to IDLE.
- Overrun:
  - PUSH with the FIFO full and no pop in the same cycle: drop the byte and set overrun.
  - PUSH and pop in the same cycle while full: both occur, occupancy is unchanged, no overrun.
- CTRL is sampled live. Clearing Rx_en mid-frame aborts to IDLE immediately with no push. FIFO contents are retained.
- A W1C write to STATUS in the same cycle an error sets: the set wins.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count register is one bit wider.
- Latency: the byte is visible in DATA 1 clk after the final stop sample. The line-to-sample offset is SYNC_STAGES clks.

Decomposition:
- Package uart_pkg:
  - register index constants (DATA=0, CTRL=1, STATUS=2, BAUD=3, COUNT=4);
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH);
  - STATUS bit position constants.
- One sub-module: uart_rx_fifo. It is synchronous, parameterised by FIFO_DEPTH, with push/pop/full/empty/count ports and simultaneous push-and-pop support.

Test Plan:
- BAUD=9, CTRL=1 (8 data bits, even parity, 1 stop); drive 0xA5 with parity 0 at 10 clk/bit -> COUNT=1, STATUS[0]=1, DATA read returns 0xA5, then COUNT=0 and rx_irq=0.
- CTRL=5 (odd parity), send 0x3C with parity bit 0 -> byte 0x3C pushed, parity_err=1; W1C write 0x04 to STATUS -> parity_err=0.
- Send 0x55 with stop bit 0 -> COUNT stays 0, frame_err=1. A following valid 0x12 is received correctly.
- Send 9 bytes 0x01..0x09 without reads -> COUNT=8, overrun=1, reads return 0x01..0x08. Repeat with a DATA pop on the PUSH cycle of byte 9 -> no overrun.
- Drive a 3-clk low glitch on Rx_in with BAUD=9 -> FSM returns to IDLE, no push, no error bits.
- CTRL=3 (two stop bits): send 0xFF with second stop bit 0 -> frame_err=1. Then assert reset mid-frame -> all registers 0, FSM in IDLE, rdata of COUNT = 0.
